// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit path.
// Mode encodings, frame-length arithmetic and a saturating increment.
package i2s_pkg;

    localparam int I2S_MODE_I2S = 0;
    localparam int I2S_MODE_LJ  = 1;
    localparam int I2S_MODE_RJ  = 2;

    function automatic int frame_len(input int slot);
        return 2 * slot;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        if (width >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (value >= max_v) begin
            return max_v;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/i2s_tx_multi_mono_mix.sv
// Combinational stereo-to-mono mix: ((L + R) >>> 1) on signed samples.
// Shared with the SPDIF path, so it carries no timing of its own.
module i2s_mono_mix #(
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic [SAMPLE_WIDTH-1:0] left,
    input  logic [SAMPLE_WIDTH-1:0] right,
    output logic [SAMPLE_WIDTH-1:0] mix
);

    logic [SAMPLE_WIDTH:0] sum_s;

    // One extra bit absorbs the carry; dropping the LSB is the arithmetic halve.
    always_comb begin
        sum_s = {left[SAMPLE_WIDTH-1], left} + {right[SAMPLE_WIDTH-1], right};
        mix   = sum_s[SAMPLE_WIDTH:1];
    end

endmodule

// File: rtl/i2s_tx_multi.sv
// Stereo I2S / left-justified / right-justified serialiser in the bclk domain.
// One frame is loaded per 2*SLOT_WIDTH bclk cycles through a ready/valid handshake.
module i2s_tx_multi
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int MODE          = 0,
    parameter int MONO_MIX      = 0,
    parameter int UNDERRUN_ZERO = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                    bclk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    mute,
    output logic                    lrclk,
    output logic                    data,
    output logic                    underrun,
    output logic [CNT_WIDTH-1:0]    underrun_count
);

    localparam int F  = frame_len(SLOT_WIDTH);
    localparam int CW = (F > 2) ? $clog2(F) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(F - 1);
    localparam logic [CW-1:0] C_RESET = CW'(F - 2);
    localparam logic [CW-1:0] C_SLOT  = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] C_LR_LO = CW'(SLOT_WIDTH - 1);

    logic [CW-1:0]           c_r;
    logic [CW-1:0]           c_next_s;
    logic                    lrclk_r;
    logic                    lr_next_s;
    logic                    data_r;
    logic                    sample_ready_r;
    logic                    underrun_r;
    logic [CNT_WIDTH-1:0]    count_r;
    logic [F-1:0]            shift_r;
    logic [F-1:0]            frame_s;
    logic [SAMPLE_WIDTH-1:0] held_l_r;
    logic [SAMPLE_WIDTH-1:0] held_r_r;
    logic [SAMPLE_WIDTH-1:0] mix_s;
    logic [SAMPLE_WIDTH-1:0] new_l_s;
    logic [SAMPLE_WIDTH-1:0] new_r_s;
    logic [SAMPLE_WIDTH-1:0] load_l_s;
    logic [SAMPLE_WIDTH-1:0] load_r_s;
    logic                    load_s;
    logic                    xfer_s;

    i2s_mono_mix #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) u_mono_mix (
        .left  (sample_left),
        .right (sample_right),
        .mix   (mix_s)
    );

    // Place a sample in its slot; frame bit F-1 is the bit shown at c=0.
    function automatic logic [SLOT_WIDTH-1:0] format_slot(input logic [SAMPLE_WIDTH-1:0] s);
        logic [SLOT_WIDTH-1:0] z;
        z = SLOT_WIDTH'(s);
        if (MODE == I2S_MODE_RJ) begin
            return z;
        end else begin
            return z << (SLOT_WIDTH - SAMPLE_WIDTH);
        end
    endfunction

    // Frame counter advance, handshake decode and next-frame selection.
    always_comb begin
        if (c_r == C_LAST) begin
            c_next_s = {CW{1'b0}};
        end else begin
            c_next_s = c_r + CW'(1);
        end

        load_s = (c_r == C_LAST);
        xfer_s = sample_ready_r && sample_valid;

        if (MONO_MIX != 0) begin
            new_l_s = mix_s;
            new_r_s = mix_s;
        end else begin
            new_l_s = sample_left;
            new_r_s = sample_right;
        end

        // Mute wins over the underrun policy; only an unmuted transfer carries new data.
        if (xfer_s && !mute) begin
            load_l_s = new_l_s;
            load_r_s = new_r_s;
        end else if (mute || (UNDERRUN_ZERO != 0)) begin
            load_l_s = {SAMPLE_WIDTH{1'b0}};
            load_r_s = {SAMPLE_WIDTH{1'b0}};
        end else begin
            load_l_s = held_l_r;
            load_r_s = held_r_r;
        end

        frame_s = {format_slot(load_l_s), format_slot(load_r_s)};

        case (MODE)
            I2S_MODE_I2S: lr_next_s = (c_next_s >= C_LR_LO) && (c_next_s <= C_RESET);
            default:      lr_next_s = (c_next_s >= C_SLOT);
        endcase
    end

    // Counter, word select and handshake pulse.
    always_ff @(posedge bclk) begin
        if (reset) begin
            c_r            <= C_RESET;
            lrclk_r        <= 1'b0;
            sample_ready_r <= 1'b0;
        end else begin
            c_r            <= c_next_s;
            lrclk_r        <= lr_next_s;
            sample_ready_r <= (c_next_s == C_LAST);
        end
    end

    // Shifter, held frame and underrun bookkeeping.
    always_ff @(posedge bclk) begin
        if (reset) begin
            data_r     <= 1'b0;
            shift_r    <= {F{1'b0}};
            held_l_r   <= {SAMPLE_WIDTH{1'b0}};
            held_r_r   <= {SAMPLE_WIDTH{1'b0}};
            underrun_r <= 1'b0;
            count_r    <= {CNT_WIDTH{1'b0}};
        end else if (load_s) begin
            data_r     <= frame_s[F-1];
            shift_r    <= {frame_s[F-2:0], 1'b0};
            underrun_r <= !xfer_s;
            if (!xfer_s) begin
                count_r <= CNT_WIDTH'(sat_inc(32'(count_r), CNT_WIDTH));
            end else begin
                count_r <= count_r;
            end
            if (xfer_s && !mute) begin
                held_l_r <= new_l_s;
                held_r_r <= new_r_s;
            end else begin
                held_l_r <= held_l_r;
                held_r_r <= held_r_r;
            end
        end else begin
            data_r     <= shift_r[F-1];
            shift_r    <= {shift_r[F-2:0], 1'b0};
            underrun_r <= 1'b0;
        end
    end

    assign sample_ready   = sample_ready_r;
    assign lrclk          = lrclk_r;
    assign data           = data_r;
    assign underrun       = underrun_r;
    assign underrun_count = count_r;

endmodule
